// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - framed register command sequencer behind the RS-232 byte receiver
//
// Purpose:
//   Assembles SYNC / CMD / data / CHK frames from the byte receiver and checks them.
//   Issues one register write or register read on the internal register bus.
//   Returns read results on a response pulse.
//   Keeps saturating counters for protocol errors and for bytes dropped while a read is pending.
//
// Build option:
//   UART_CMD_CHECKSUM_EN defined   : every frame ends with a CHK byte (XOR of CMD and data bytes).
//                                    The CHK byte is compared before the bus is touched.
//   UART_CMD_CHECKSUM_EN undefined : there is no CHK byte.
//                                    A write executes after DLO; a read starts after CMD.
//
// Ports:
//   clk, rst_n                        system clock, asynchronous active-low reset
//   rx_valid, rx_data, rx_eop         byte-valid pulse, byte, and end-of-packet pulse from the receiver
//   reg_addr, reg_wdata               register address and write data; both hold between commands
//   reg_wr                            one-cycle write strobe
//   reg_rd                            read request level, held until rd_ack or timeout
//   rd_ack, rd_data                   read completion and read data from the register bus
//   resp_valid, resp_data, resp_ok    read response pulse; data is 0 and ok is 0 on timeout
//   cmd_busy                          high whenever the sequencer is not idle
//   err_clr                           synchronous clear of both counters
//   err_cnt, ovr_cnt                  saturating protocol-error and dropped-byte counters

module uart_cmd_sequencer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_eop,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_ok,
  output logic        cmd_busy,
  input  logic        err_clr,
  output logic [7:0]  err_cnt,
  output logic [7:0]  ovr_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_DHI     = 3'd2;
  localparam logic [2:0] S_DLO     = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd4;
`endif

  // The wait counter starts at 0 in the first RD_WAIT cycle.
  // The read is therefore abandoned after RD_TIMEOUT cycles of reg_rd high.
  localparam logic [15:0] TO_LAST = 16'(RD_TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] tcnt;
  logic        err_inc;
  logic        ovr_inc;
  logic        timeout_hit;

`ifdef UART_CMD_CHECKSUM_EN
  logic        rw_read;
  logic [7:0]  chk;
`endif

  assign cmd_busy    = (state != S_IDLE);
  assign timeout_hit = (tcnt == TO_LAST);

  // Error and overrun events for this cycle.
  // rx_eop takes priority over a byte arriving in the same cycle, so an aborted frame is never also
  // counted as a checksum mismatch.
  // An ack on the final wait cycle is a success, not a timeout.
  always_comb begin
    err_inc = 1'b0;
    ovr_inc = 1'b0;
    case (state)
      S_CMD, S_DHI, S_DLO: err_inc = rx_eop;
`ifdef UART_CMD_CHECKSUM_EN
      S_CHK:               err_inc = rx_eop | (rx_valid & (rx_data != chk));
`endif
      S_RD_WAIT: begin
        err_inc = ~rd_ack & timeout_hit;
        ovr_inc = rx_valid;
      end
      default: begin
        err_inc = 1'b0;
        ovr_inc = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tcnt       <= 16'h0000;
      reg_addr   <= 7'h00;
      reg_wdata  <= 16'h0000;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_ok    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      rw_read    <= 1'b0;
      chk        <= 8'h00;
`endif
    end else begin
      reg_wr     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Anything other than the sync marker is line noise and is dropped silently.
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= S_CMD;
          end
        end

        S_CMD: begin
          if (rx_eop) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            reg_addr <= rx_data[6:0];
`ifdef UART_CMD_CHECKSUM_EN
            rw_read  <= rx_data[7];
            chk      <= rx_data;
            state    <= rx_data[7] ? S_CHK : S_DHI;
`else
            if (rx_data[7]) begin
              reg_rd <= 1'b1;
              tcnt   <= 16'h0000;
              state  <= S_RD_WAIT;
            end else begin
              state  <= S_DHI;
            end
`endif
          end
        end

        S_DHI: begin
          if (rx_eop) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            reg_wdata[15:8] <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            chk             <= chk ^ rx_data;
`endif
            state           <= S_DLO;
          end
        end

        S_DLO: begin
          if (rx_eop) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            reg_wdata[7:0] <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            chk            <= chk ^ rx_data;
            state          <= S_CHK;
`else
            reg_wr         <= 1'b1;
            state          <= S_IDLE;
`endif
          end
        end

`ifdef UART_CMD_CHECKSUM_EN
        S_CHK: begin
          if (rx_eop) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            if (rx_data != chk) begin
              state <= S_IDLE;
            end else if (rw_read) begin
              reg_rd <= 1'b1;
              tcnt   <= 16'h0000;
              state  <= S_RD_WAIT;
            end else begin
              reg_wr <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
`endif

        S_RD_WAIT: begin
          if (rd_ack) begin
            resp_valid <= 1'b1;
            resp_data  <= rd_data;
            resp_ok    <= 1'b1;
            reg_rd     <= 1'b0;
            state      <= S_IDLE;
          end else if (timeout_hit) begin
            resp_valid <= 1'b1;
            resp_data  <= 16'h0000;
            resp_ok    <= 1'b0;
            reg_rd     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tcnt <= tcnt + 16'h0001;
          end
        end

        default: begin
          reg_rd <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Clear beats a simultaneous increment.
  // The two counters otherwise move independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
      ovr_cnt <= 8'h00;
    end else if (err_clr) begin
      err_cnt <= 8'h00;
      ovr_cnt <= 8'h00;
    end else begin
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
      if (ovr_inc && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - self-checking bench for uart_cmd_sequencer
//
// Purpose: directed frames plus randomized traffic against a frame-level reference model.
// Build option: UART_CMD_CHECKSUM_EN selects frames with a trailing CHK byte.

module tb_uart_cmd_sequencer;

  localparam int         RD_TO = 10;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, rx_eop, err_clr, rd_ack;
  logic [7:0]  rx_data;
  logic [15:0] rd_data;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata, resp_data;
  logic        reg_wr, reg_rd, resp_valid, resp_ok, cmd_busy;
  logic [7:0]  err_cnt, ovr_cnt;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.SYNC_BYTE(SYNC), .RD_TIMEOUT(RD_TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eop(rx_eop),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .rd_ack(rd_ack), .rd_data(rd_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ok(resp_ok), .cmd_busy(cmd_busy), .err_clr(err_clr), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected outputs after the next clock edge
  logic [6:0]  e_addr;
  logic [15:0] e_wdata, e_rdata;
  logic        e_wr, e_rd, e_rv, e_rok, e_busy;
  logic [7:0]  e_err, e_ovr;
  logic [7:0]  fr[$];        // bytes of the current frame after SYNC
  bit          in_frame, waiting;
  int          wcnt, m_need;
  bit          m_err_inc, m_ovr_inc, m_good;
  logic [7:0]  m_x;

  // Read responder and pulse bookkeeping
  int          ack_delay = -1;
  logic [15:0] ack_value = 16'h0000;
  int          rd_cnt = 0;
  int          wr_pulses = 0, rv_pulses = 0, rd_high = 0;
  logic [15:0] last_rdata = 16'h0000;
  logic        last_rok = 1'b0;
  int          s_wr, s_rv, s_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_bus();
    return {4'h0, reg_addr, reg_wdata, reg_wr, reg_rd, resp_valid, resp_data, resp_ok, cmd_busy, err_cnt, ovr_cnt};
  endfunction

  function automatic logic [63:0] model_bus();
    return {4'h0, e_addr, e_wdata, e_wr, e_rd, e_rv, e_rdata, e_rok, e_busy, e_err, e_ovr};
  endfunction

  task automatic model_reset();
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wr = 0; e_rd = 0; e_rv = 0; e_rok = 0; e_busy = 0;
    e_err = '0; e_ovr = '0; fr.delete(); in_frame = 0; waiting = 0; wcnt = 0;
  endtask

  // Advances the model across one clock edge using the inputs now applied
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err_inc = 0; m_ovr_inc = 0; e_wr = 0; e_rv = 0;
    if (waiting) begin
      if (rx_valid) m_ovr_inc = 1;
      if (rd_ack) begin
        e_rv = 1; e_rdata = rd_data; e_rok = 1; waiting = 0;
      end else if (wcnt == RD_TO - 1) begin
        e_rv = 1; e_rdata = '0; e_rok = 0; waiting = 0; m_err_inc = 1;
      end else begin
        wcnt++;
      end
    end else if (in_frame) begin
      if (rx_eop) begin
        in_frame = 0; m_err_inc = 1;
      end else if (rx_valid) begin
        fr.push_back(rx_data);
        if (fr.size() == 1) e_addr = rx_data[6:0];
        else if (!fr[0][7] && fr.size() == 2) e_wdata[15:8] = rx_data;
        else if (!fr[0][7] && fr.size() == 3) e_wdata[7:0] = rx_data;
        m_need = (fr[0][7] ? 1 : 3) + (CHK_EN ? 1 : 0);
        if (fr.size() == m_need) begin
          in_frame = 0;
          m_good = 1;
          if (CHK_EN) begin
            m_x = 8'h00;
            for (int k = 0; k < m_need - 1; k++) m_x = m_x ^ fr[k];
            m_good = (m_x == fr[m_need-1]);
          end
          if (!m_good) m_err_inc = 1;
          else if (fr[0][7]) begin waiting = 1; wcnt = 0; end
          else e_wr = 1;
        end
      end
    end else if (rx_valid && rx_data == SYNC) begin
      in_frame = 1; fr.delete();
    end
    if (err_clr) begin
      e_err = '0; e_ovr = '0;
    end else begin
      if (m_err_inc && e_err != 8'hFF) e_err = e_err + 8'h01;
      if (m_ovr_inc && e_ovr != 8'hFF) e_ovr = e_ovr + 8'h01;
    end
    e_rd = waiting;
    e_busy = in_frame || waiting;
  endtask

  // One clock cycle: compare, bookkeeping, responder, new inputs, model step
  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic c);
    @(negedge clk); #1;
    check("outputs", dut_bus(), model_bus());
    if (reg_wr) wr_pulses++;
    if (resp_valid) begin rv_pulses++; last_rdata = resp_data; last_rok = resp_ok; end
    if (reg_rd) rd_high++;
    rd_ack = 1'b0;
    rd_data = 16'($urandom);
    if (reg_rd) begin
      rd_cnt++;
      if (rd_cnt == ack_delay) begin rd_ack = 1'b1; rd_data = ack_value; end
    end else begin
      rd_cnt = 0;
    end
    rx_valid = v; rx_data = d; rx_eop = e; err_clr = c;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    drive(1'b1, b, 1'b0, 1'b0);
    idle(gap);
  endtask

  task automatic send_frame(input logic rd, input logic [6:0] addr, input logic [15:0] data,
                            input logic bad, input int gap);
    logic [7:0] cmd, c;
    cmd = {rd, addr};
    send(SYNC, gap);
    send(cmd, gap);
    c = cmd;
    if (!rd) begin
      send(data[15:8], gap);
      send(data[7:0], gap);
      c = c ^ data[15:8] ^ data[7:0];
    end
    if (CHK_EN) send(bad ? (c ^ 8'h07) : c, gap);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cmd_busy || reg_rd) && n < 200) begin idle(1); n++; end
    check("idle_reached", 64'(cmd_busy | reg_rd), 64'h0);
    idle(1);
  endtask

  task automatic snap();
    s_wr = wr_pulses; s_rv = rv_pulses; s_rd = rd_high;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 0; rx_data = 0; rx_eop = 0; err_clr = 0; rd_ack = 0; rd_data = 0;
    model_reset();
    idle(3);
    check("reset_outputs", dut_bus(), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Write A5 05 12 34 (23)
    snap();
    send_frame(1'b0, 7'h05, 16'h1234, 1'b0, 0);
    wait_idle();
    check("wr_pulse_count", 64'(wr_pulses - s_wr), 64'd1);
    check("wr_addr", 64'(reg_addr), 64'h05);
    check("wr_data", 64'(reg_wdata), 64'h1234);
    check("model_wdata", 64'(e_wdata), 64'h1234);
    check("wr_err_cnt", 64'(err_cnt), 64'h0);
    check("wr_busy", 64'(cmd_busy), 64'h0);

    // Read A5 83 (83), ack 3 cycles after reg_rd rises
    ack_delay = 3; ack_value = 16'hBEEF;
    snap();
    send_frame(1'b1, 7'h03, 16'h0000, 1'b0, 0);
    wait_idle();
    check("rd_resp_count", 64'(rv_pulses - s_rv), 64'd1);
    check("rd_resp_data", 64'(last_rdata), 64'hBEEF);
    check("rd_resp_ok", 64'(last_rok), 64'h1);
    check("rd_addr", 64'(reg_addr), 64'h03);
    check("rd_req_cycles", 64'(rd_high - s_rd), 64'd3);

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum A5 05 12 34 24, then a good write
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    snap();
    send_frame(1'b0, 7'h05, 16'h1234, 1'b1, 0);
    wait_idle();
    check("badchk_no_write", 64'(wr_pulses - s_wr), 64'd0);
    check("badchk_err_cnt", 64'(err_cnt), 64'd1);
    send_frame(1'b0, 7'h06, 16'hABCD, 1'b0, 0);
    wait_idle();
    check("after_bad_write", 64'(wr_pulses - s_wr), 64'd1);
    check("after_bad_wdata", 64'(reg_wdata), 64'hABCD);
`endif

    // Abort: A5 05 12 then eop
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    snap();
    send(SYNC, 0); send(8'h05, 0); send(8'h12, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    check("abort_err_cnt", 64'(err_cnt), 64'd1);
    check("abort_busy", 64'(cmd_busy), 64'h0);
    check("abort_no_write", 64'(wr_pulses - s_wr), 64'd0);

    // Timeout with two overrun bytes
    ack_delay = -1;
    snap();
    send_frame(1'b1, 7'h10, 16'h0000, 1'b0, 0);
    send(8'h11, 0); send(8'h22, 0);
    wait_idle();
    check("to_resp_count", 64'(rv_pulses - s_rv), 64'd1);
    check("to_resp_ok", 64'(last_rok), 64'h0);
    check("to_resp_data", 64'(last_rdata), 64'h0);
    check("to_req_cycles", 64'(rd_high - s_rd), 64'd10);
    check("to_err_cnt", 64'(err_cnt), 64'd2);
    check("to_ovr_cnt", 64'(ovr_cnt), 64'd2);

    // Saturation, then clear alongside an error
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      send(SYNC, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    idle(1);
    check("sat_err_cnt", 64'(err_cnt), 64'd255);
    check("model_sat", 64'(e_err), 64'd255);
    send(SYNC, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    idle(1);
    check("clr_wins", 64'(err_cnt), 64'd0);

    // Reset during RD_WAIT
    ack_delay = -1;
    send_frame(1'b1, 7'h22, 16'h0000, 1'b0, 0);
    send(8'h33, 0);
    idle(1);
    check("pre_reset_rd", 64'(reg_rd), 64'h1);
    check("pre_reset_ovr", 64'(ovr_cnt), 64'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_rd", 64'(reg_rd), 64'h0);
    check("reset_busy", 64'(cmd_busy), 64'h0);
    check("reset_cnts", 64'({err_cnt, ovr_cnt}), 64'h0);
    check("reset_addr", 64'(reg_addr), 64'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int kind, gap, k;
      kind = $urandom_range(0, 6);
      gap = $urandom_range(0, 2);
      case (kind)
        0: send_frame(1'b0, 7'($urandom), 16'($urandom), 1'b0, gap);
        1: begin
          ack_delay = $urandom_range(1, RD_TO + 2);
          ack_value = 16'($urandom);
          send_frame(1'b1, 7'($urandom), 16'h0000, 1'b0, gap);
          k = $urandom_range(0, 3);
          repeat (k) drive(1'b1, 8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0);
        end
        2: send_frame(1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom), 1'b1, gap);
        3: begin
          send(SYNC, gap);
          k = $urandom_range(0, 2);
          if (k > 0) send({1'b0, 7'($urandom)}, gap);
          if (k > 1) send(8'($urandom), gap);
          drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
        end
        4: repeat ($urandom_range(1, 4))
             drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0);
        5: drive(1'b0, 8'h00, 1'b0, 1'b1);
        default: begin
          send_frame(1'b0, 7'($urandom), 16'($urandom), 1'b0, 0);
          send_frame(1'b0, 7'($urandom), 16'($urandom), 1'b0, 0);
        end
      endcase
      wait_idle();
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command-frame controller that sits directly after the RS-232 byte receiver. It consumes the receiver's byte-valid, data and end-of-packet outputs.
- Assembles framed register commands from the PC, checks them, and sequences one register write or register read on the internal register bus.
- Returns read data to the PC path over a response handshake.
- Keeps saturating counters for protocol errors and for bytes dropped during overrun.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- RD_TIMEOUT, 255, clk cycles to wait for rd_ack before a read is aborted (1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse, rx_data valid (receiver data-ready)
- rx_data  in  8  received byte
- rx_eop  in  1  one-cycle pulse, inter-byte gap detected (receiver end-of-packet)
- reg_addr  out  7  register address
- reg_wdata  out  16  register write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  read request, level, held until rd_ack or timeout
- rd_ack  in  1  read data valid / request accepted
- rd_data  in  16  register read data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  16  read result (0 on timeout)
- resp_ok  out  1  1 = successful read, 0 = timeout; valid with resp_valid
- cmd_busy  out  1  state != IDLE
- err_clr  in  1  synchronous clear of both counters
- err_cnt  out  8  protocol error count, saturates at 255
- ovr_cnt  out  8  dropped-byte count, saturates at 255

Behaviour:

Reset and clocking:
- One clock domain, clk.
- rst_n is asynchronous and active-low.
- While rst_n is low, every output and register is 0 and the state is IDLE.
- Reset mid-frame discards the frame and does not count it.

Frame format:
- SYNC, then CMD (bit7 = 1 read / 0 write, bits 6:0 = addr).
- Write frames follow CMD with DHI, DLO, CHK.
- Read frames follow CMD with CHK only.
- CHK = XOR of CMD and all data bytes; SYNC is excluded.

States: IDLE, CMD, DHI, DLO, CHK, RD_WAIT.
- IDLE: rx_valid with rx_data == SYNC_BYTE -> CMD. Any other byte is discarded silently, with no count.
- CMD: on rx_valid, latch reg_addr and the rw flag, and set chk = byte. A write goes to DHI; a read goes to CHK.
- DHI / DLO: latch reg_wdata[15:8] / [7:0] and update chk ^= byte. DHI -> DLO -> CHK.
- CHK: on rx_valid, compare the byte with chk.
  - Match + write: reg_wr is high for exactly 1 cycle, in the cycle after the CHK byte's rx_valid, then -> IDLE.
  - Match + read: reg_rd rises in the cycle after the CHK byte's rx_valid -> RD_WAIT.
  - Mismatch: err_cnt +1, -> IDLE, no bus activity.
- RD_WAIT: reg_rd stays high and the timeout counter runs from 0.
  - rd_ack high: in the next cycle resp_valid = 1, resp_data = rd_data (captured on the ack cycle), resp_ok = 1; reg_rd drops in that same cycle; -> IDLE.
  - Counter reaches RD_TIMEOUT with no ack: resp_valid = 1, resp_ok = 0, resp_data = 0, err_cnt +1, reg_rd drops, -> IDLE.
  - An ack that arrives on the timeout cycle counts as success.
- Overrun: any rx_valid during RD_WAIT is dropped and ovr_cnt +1.
- Abort: rx_eop in CMD, DHI, DLO or CHK -> IDLE and err_cnt +1.
  - If rx_eop and rx_valid occur in the same cycle, eop wins and the byte is discarded.
  - rx_eop in IDLE or RD_WAIT is ignored.
- reg_addr and reg_wdata hold their last values between commands.
- Counters:
  - Saturate at 255, with no wrap.
  - err_clr zeroes both counters and wins over a simultaneous increment.
  - In the same cycle, an err increment and an ovr increment are independent.
- Back-to-back frames: SYNC may arrive in the cycle after a frame completes, with no idle gap required.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined: CHK byte is present and checked as described above.
- Undefined: no CHK state. The write executes after DLO: reg_wr is high in the cycle after DLO's rx_valid. The read starts after CMD: reg_rd rises in the cycle after CMD's rx_valid. Mismatch errors cannot occur.

Test Plan:
- Write: bytes A5, 05, 12, 34, 23 -> single reg_wr pulse, reg_addr = 05, reg_wdata = 1234, err_cnt = 0, cmd_busy low afterwards.
- Read: A5, 83, 83; rd_ack 3 cycles after reg_rd rises with rd_data = BEEF -> resp_valid pulse, resp_data = BEEF, resp_ok = 1, reg_addr = 03.
- Bad checksum: A5, 05, 12, 34, 24 -> no reg_wr, err_cnt = 1. Then a valid write frame follows and executes.
- Abort and overrun:
  - A5, 05, 12, then rx_eop -> IDLE, err_cnt = 1.
  - Read with rd_ack never asserted, RD_TIMEOUT = 10 -> resp_valid with resp_ok = 0 after 10 cycles, err_cnt = 2.
  - 2 bytes received during the wait -> ovr_cnt = 2.
- Saturation and clear: 300 bad frames -> err_cnt = 255. err_clr pulsed alongside a simultaneous error -> err_cnt = 0.
- Reset mid-read: assert rst_n low during RD_WAIT -> reg_rd = 0 immediately, state IDLE, counters 0.
